iic_arbiter: RTL
================

Name: iic_arbiter

Overview:
- Shares the single I2C byte-master (iic_start/iic_data/dc/iic_done interface) between two requesters.
- Client 0 is the OLED display sequencer; client 1 is the sensor poller.
- Grants are per-requester sessions, round-robin, with a transfer-count fairness limit and a lock input that keeps multi-byte command sequences unbroken.
- Sits between the client controllers and the I2C master.

Parameters:
MAX_XFER, 16, transfers a holder may complete before it must yield to a pending other client (lock low only); range 1..255
TIMEOUT_CYC, 1000, idle-grant timeout in clk cycles (used only with ARB_TIMEOUT_EN); range 1..2^24-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
c0_req  in  1  client 0 requests the bus; held high for the whole session
c0_lock  in  1  client 0 forbids fairness preemption while high
c0_start  in  1  client 0 one-cycle transfer strobe; valid only while c0_gnt=1
c0_data  in  8  client 0 byte
c0_dc  in  1  client 0 data/command flag
c0_gnt  out  1  grant to client 0
c0_done  out  1  one-cycle completion pulse to client 0
c1_req, c1_lock, c1_start, c1_data[8], c1_dc, c1_gnt, c1_done: same as client 0, for client 1
iic_start  out  1  one-cycle start pulse to the I2C master
iic_data  out  8  byte to the I2C master
dc  out  1  data/command flag to the I2C master
iic_done  in  1  one-cycle completion pulse from the I2C master
err_timeout  out  1  sticky timeout flag; cleared only by rst

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE; c0_gnt, c1_gnt, c0_done, c1_done, iic_start, dc, err_timeout = 0; iic_data = 0; xfer_cnt = 0; last_gnt = 1, so client 0 wins the first tie.
- Reset mid-transfer: the arbiter drops everything immediately. A later iic_done is ignored because the state is IDLE.
- States: IDLE, GRANT, BUSY.
- IDLE:
  - If exactly one req is high, grant that client.
  - If both are high, grant the client that is not last_gnt.
  - On grant: set cN_gnt=1 on the next edge, state=GRANT, xfer_cnt=0, last_gnt=N.
  - The grant is visible one cycle after req is sampled.
- GRANT:
  - If the holder's cN_start=1: latch cN_data into iic_data and cN_dc into dc, pulse iic_start=1 for exactly the next cycle, and go to BUSY. Start-to-iic_start latency is 1 cycle.
  - Else if the holder's req=0: drop the grant and go to IDLE. The other client can be granted no earlier than the following cycle, so there is one dead cycle.
  - Start and req-drop in the same cycle: start wins, and the session ends after that transfer's done.
- BUSY:
  - Wait for iic_done. On iic_done, pulse the holder's cN_done one cycle later and increment xfer_cnt (saturating at 255).
  - Then evaluate, using signals sampled in the iic_done cycle:
    - holder req=0 → IDLE, grant dropped;
    - else if the other req=1, holder lock=0 and xfer_cnt+1 ≥ MAX_XFER → IDLE with grant dropped (preemption). The other client is then granted by the IDLE rule;
    - else → GRANT.
  - cN_done and the grant drop appear in the same cycle.
- Ignored inputs:
  - cN_start from a non-holder is ignored in all states.
  - cN_start in BUSY or IDLE is ignored.
  - iic_done outside BUSY is ignored.
- Output holding: iic_data and dc hold their last latched values between transfers. Exactly one gnt is high at any time, or none.
- The lock input is sampled only at the preemption decision. Raising lock never revokes the other client's pending request.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter runs in GRANT and clears on entry to GRANT and on every accepted start.
  - When the counter reaches TIMEOUT_CYC, the grant is revoked regardless of lock, state goes to IDLE, and err_timeout is set to 1 (sticky).
  - The counter does not run in BUSY; the I2C master bounds that state.
- Undefined: no counter is present, err_timeout is tied to 0, and a holder may keep the grant indefinitely.

Test Plan:
1. Reset, then c0_req=1 → c0_gnt=1 one cycle later; c0_start with data 8'hAE, dc=0 → next cycle iic_start=1, iic_data=8'hAE, dc=0; iic_done → c0_done pulses once, state returns to GRANT.
2. c0_req and c1_req rise in the same cycle after reset → c0 granted first. c0 completes 1 transfer and drops req → c1_gnt=1 after one dead cycle.
3. MAX_XFER=4, c0 streaming with lock=0, c1_req held → c0_done of transfer 4 coincides with c0_gnt=0; c1_gnt=1 one cycle later.
4. Same as 3 with c0_lock=1 → c0 keeps the grant for 10 transfers. Lowering lock before the 11th done → preempted at the 11th done.
5. c1_start pulsed while c0 holds the grant, and an iic_done pulse in GRANT → no iic_start, no cN_done, no state change. rst asserted in BUSY → all outputs 0 next cycle; a stale iic_done is ignored.
6. (ARB_TIMEOUT_EN, TIMEOUT_CYC=50) c1 granted, no start for 50 cycles → c1_gnt=0 and err_timeout=1, held until rst.

Source files
------------

// File: rtl/iic_arbiter.sv
// iic_arbiter: round-robin share of one I2C byte master between two clients.
// Optional ARB_TIMEOUT_EN revokes an idle grant after TIMEOUT_CYC cycles.
module iic_arbiter #(
    parameter int MAX_XFER    = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c0_req,
    input  logic       c0_lock,
    input  logic       c0_start,
    input  logic [7:0] c0_data,
    input  logic       c0_dc,
    output logic       c0_gnt,
    output logic       c0_done,
    input  logic       c1_req,
    input  logic       c1_lock,
    input  logic       c1_start,
    input  logic [7:0] c1_data,
    input  logic       c1_dc,
    output logic       c1_gnt,
    output logic       c1_done,
    output logic       iic_start,
    output logic [7:0] iic_data,
    output logic       dc,
    input  logic       iic_done,
    output logic       err_timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    logic [1:0] state;
    logic       last_gnt;
    logic [7:0] xfer_cnt;

    // last_gnt doubles as the holder index while a session is open
    logic       h_req;
    logic       h_lock;
    logic       h_start;
    logic [7:0] h_data;
    logic       h_dc;
    logic       o_req;
    logic       pick;
    logic [8:0] cnt_nxt;
    logic       preempt;

    assign h_req   = last_gnt ? c1_req   : c0_req;
    assign h_lock  = last_gnt ? c1_lock  : c0_lock;
    assign h_start = last_gnt ? c1_start : c0_start;
    assign h_data  = last_gnt ? c1_data  : c0_data;
    assign h_dc    = last_gnt ? c1_dc    : c0_dc;
    assign o_req   = last_gnt ? c0_req   : c1_req;
    assign pick    = (c0_req & c1_req) ? ~last_gnt : c1_req;
    assign cnt_nxt = {1'b0, xfer_cnt} + 9'd1;
    assign preempt = o_req & ~h_lock & (cnt_nxt >= 9'(MAX_XFER));

`ifdef ARB_TIMEOUT_EN
    logic [23:0] tmr;
    logic        tmr_hit;

    assign tmr_hit = (tmr == 24'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr         <= '0;
            err_timeout <= 1'b0;
        end else if (state != GRANT) begin
            tmr <= '0;
        end else if (h_start || !h_req) begin
            tmr <= '0;
        end else if (tmr_hit) begin
            tmr         <= '0;
            err_timeout <= 1'b1;
        end else begin
            tmr <= tmr + 24'd1;
        end
    end
`else
    logic tmr_hit;

    assign tmr_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            xfer_cnt  <= '0;
            c0_gnt    <= 1'b0;
            c1_gnt    <= 1'b0;
            c0_done   <= 1'b0;
            c1_done   <= 1'b0;
            iic_start <= 1'b0;
            iic_data  <= '0;
            dc        <= 1'b0;
        end else begin
            iic_start <= 1'b0;
            c0_done   <= 1'b0;
            c1_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        last_gnt <= pick;
                        c0_gnt   <= ~pick;
                        c1_gnt   <= pick;
                        xfer_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (h_start) begin
                        iic_data  <= h_data;
                        dc        <= h_dc;
                        iic_start <= 1'b1;
                        state     <= BUSY;
                    end else if (!h_req || tmr_hit) begin
                        c0_gnt <= 1'b0;
                        c1_gnt <= 1'b0;
                        state  <= IDLE;
                    end
                end
                BUSY: begin
                    if (iic_done) begin
                        c0_done <= ~last_gnt;
                        c1_done <= last_gnt;
                        if (xfer_cnt != 8'hFF) begin
                            xfer_cnt <= cnt_nxt[7:0];
                        end
                        if (!h_req || preempt) begin
                            c0_gnt <= 1'b0;
                            c1_gnt <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= GRANT;
                        end
                    end
                end
                default: begin
                    c0_gnt <= 1'b0;
                    c1_gnt <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
